// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment capture block.
package seg7_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NUM_HEX = 16;

    typedef logic [SEG_W-1:0] seg7_t;
    typedef logic [NIB_W-1:0] nibble_t;

    // Active-high patterns {a,b,c,d,e,f,g}, indexed by hex value
    localparam seg7_t SEG7_HEX [NUM_HEX] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    // Decoder result: recovered nibble plus an undecodable-pattern flag
    typedef struct packed {
        nibble_t value;
        logic    err;
    } seg7_dec_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/seg7_frame_capture_if.sv
// Frame hand-off bus: valid/ready with per-digit nibbles and error flags.
interface seg7_frame_capture_if
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) ();

    logic                        frame_valid;
    logic                        frame_ready;
    logic [NIB_W*NUM_DIGITS-1:0] frame_data;
    logic [NUM_DIGITS-1:0]       frame_err;

    modport master (
        output frame_valid,
        output frame_data,
        output frame_err,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  frame_data,
        input  frame_err,
        output frame_ready
    );

endinterface

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of a 7-segment pattern into a hex nibble.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  seg7_t     seg,
    output seg7_dec_t dec
);

    // Table search; unknown patterns return nibble 0 with err set
    always_comb begin
        dec = '{value: '0, err: 1'b1};
        for (int unsigned i = 0; i < NUM_HEX; i++) begin
            if (seg == SEG7_HEX[i]) begin
                dec.value = nibble_t'(i);
                dec.err   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_frame_capture.sv
// Watches a multiplexed 7-segment bus, decodes each stable digit and
// hands complete frames out on a valid/ready interface.
module seg7_frame_capture
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned STABLE_CYCLES  = 3,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  seg7_t                  seg_in,
    input  logic [NUM_DIGITS-1:0]  dig_en,
    seg7_frame_capture_if.master   frame,
    output logic                   overflow
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    seg7_t                  seg_norm;
    seg7_t                  samp_seg;
    logic [NUM_DIGITS-1:0]  samp_dig;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   same;
    logic                   dig_onehot;
    logic [IDX_W-1:0]       dig_idx;
    logic                   capture;
    seg7_dec_t              dec;

    logic [NUM_DIGITS-1:0][NIB_W-1:0] slot;
    logic [NUM_DIGITS-1:0]            slot_err;
    logic [NUM_DIGITS-1:0]            mask;
    logic                             frame_done;

    out_state_t                       state;
    logic                             valid_q;
    logic [NIB_W*NUM_DIGITS-1:0]      data_q;
    logic [NUM_DIGITS-1:0]            err_q;
    logic                             overflow_q;

    assign seg_norm = SEG_ACTIVE_LOW ? ~seg_in : seg_in;

    seg7_to_hex u_dec (
        .seg (seg_norm),
        .dec (dec)
    );

    // Stability tracking, digit-select decode and the capture strobe
    always_comb begin
        same       = (seg_norm == samp_seg) && (dig_en == samp_dig);
        cnt_next   = CNT_W'(1);
        if (same) begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end
        dig_onehot = (dig_en != '0) && ((dig_en & (dig_en - NUM_DIGITS'(1))) == '0);
        dig_idx    = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (dig_en[i]) begin
                dig_idx = dig_idx | IDX_W'(i);
            end
        end
        // Fires only on reaching the threshold, never while sitting saturated
        capture    = (cnt_next == CNT_MAX) && !(same && (cnt == CNT_MAX)) && dig_onehot;
        frame_done = &mask;
    end

    // Sample register and stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_seg <= '0;
            samp_dig <= '0;
            cnt      <= '0;
        end else begin
            samp_seg <= seg_norm;
            samp_dig <= dig_en;
            cnt      <= cnt_next;
        end
    end

    // Digit slots and capture mask; a completed frame clears the mask
    always_ff @(posedge clk) begin
        if (rst) begin
            slot     <= '0;
            slot_err <= '0;
            mask     <= '0;
        end else begin
            if (capture) begin
                slot[dig_idx]     <= dec.value;
                slot_err[dig_idx] <= dec.err;
            end
            mask <= (frame_done ? '0 : mask) | (capture ? dig_en : '0);
        end
    end

    // Output FSM: loads assembled frames, drops them while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            valid_q    <= 1'b0;
            data_q     <= '0;
            err_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            case (state)
                ST_EMPTY: begin
                    if (frame_done) begin
                        data_q  <= slot;
                        err_q   <= slot_err;
                        valid_q <= 1'b1;
                        state   <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (frame.frame_ready) begin
                        if (frame_done) begin
                            data_q <= slot;
                            err_q  <= slot_err;
                        end else begin
                            valid_q <= 1'b0;
                            state   <= ST_EMPTY;
                        end
                    end else if (frame_done) begin
                        overflow_q <= 1'b1;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= ST_EMPTY;
                end
            endcase
        end
    end

    assign frame.frame_valid = valid_q;
    assign frame.frame_data  = data_q;
    assign frame.frame_err   = err_q;
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_seg7_frame_capture.sv
// Scoreboard bench: stimulus pushes expected frames, monitors pop on handshake.
module tb_seg7_frame_capture;
    import seg7_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  err;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    seg7_t       seg_a, seg_b;
    logic [3:0]  dig_a, dig_b;
    logic        ovf_a, ovf_b;

    frame_t      q_a[$];
    frame_t      q_b[$];
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          ovf_seen_a = 0;
    int          ovf_seen_b = 0;

    always #5 clk = ~clk;

    seg7_frame_capture_if #(.NUM_DIGITS(4)) if_a ();
    seg7_frame_capture_if #(.NUM_DIGITS(4)) if_b ();

    seg7_frame_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(3), .SEG_ACTIVE_LOW(1'b0)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .seg_in   (seg_a),
        .dig_en   (dig_a),
        .frame    (if_a),
        .overflow (ovf_a)
    );

    seg7_frame_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(3), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .seg_in   (seg_b),
        .dig_en   (dig_b),
        .frame    (if_b),
        .overflow (ovf_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic show_a(input seg7_t s, input logic [3:0] d, input int n);
        seg_a = s;
        dig_a = d;
        wait_cyc(n);
    endtask

    // Drives the logical pattern inverted onto the active-low instance
    task automatic show_b(input seg7_t s, input logic [3:0] d, input int n);
        seg_b = ~s;
        dig_b = d;
        wait_cyc(n);
    endtask

    // Monitor for the active-high instance
    always @(negedge clk) begin : mon_a
        frame_t e;
        if (!rst) begin
            if (ovf_a) ovf_seen_a++;
            if (if_a.frame_valid && if_a.frame_ready) begin
                if (q_a.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL a_unexpected_frame: got %0h, expected no frame", if_a.frame_data);
                end else begin
                    e = q_a.pop_front();
                    check("a_frame_data", 32'(if_a.frame_data), 32'(e.data));
                    check("a_frame_err", 32'(if_a.frame_err), 32'(e.err));
                end
            end
        end
    end

    // Monitor for the active-low instance
    always @(negedge clk) begin : mon_b
        frame_t e;
        if (!rst) begin
            if (ovf_b) ovf_seen_b++;
            if (if_b.frame_valid && if_b.frame_ready) begin
                if (q_b.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_unexpected_frame: got %0h, expected no frame", if_b.frame_data);
                end else begin
                    e = q_b.pop_front();
                    check("b_frame_data", 32'(if_b.frame_data), 32'(e.data));
                    check("b_frame_err", 32'(if_b.frame_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        logic [3:0] oh;
        rst              = 1'b1;
        seg_a            = 7'h00;
        dig_a            = 4'b0000;
        seg_b            = 7'h7F;
        dig_b            = 4'b0000;
        if_a.frame_ready = 1'b0;
        if_b.frame_ready = 1'b1;
        wait_cyc(2);

        check("rst_valid", 32'(if_a.frame_valid), 32'd0);
        check("rst_data", 32'(if_a.frame_data), 32'd0);
        check("rst_err", 32'(if_a.frame_err), 32'd0);
        check("rst_overflow", 32'(ovf_a), 32'd0);
        check("rst_valid_b", 32'(if_b.frame_valid), 32'd0);
        rst = 1'b0;

        // Frame 0123, valid one cycle after the last capture
        q_a.push_back('{data: 16'h0123, err: 4'h0});
        show_a(7'h79, 4'b0001, 5);
        show_a(7'h6D, 4'b0010, 5);
        show_a(7'h30, 4'b0100, 5);
        show_a(7'h7E, 4'b1000, 3);
        check("t1_valid_at_capture", 32'(if_a.frame_valid), 32'd0);
        wait_cyc(1);
        check("t1_valid_after", 32'(if_a.frame_valid), 32'd1);
        check("t1_data", 32'(if_a.frame_data), 32'h0123);
        wait_cyc(1);

        // Second frame while stalled: dropped with a single overflow pulse
        show_a(7'h33, 4'b0001, 5);
        show_a(7'h5B, 4'b0010, 5);
        show_a(7'h5F, 4'b0100, 5);
        show_a(7'h70, 4'b1000, 3);
        check("t2_ovf_before", 32'(ovf_a), 32'd0);
        wait_cyc(1);
        check("t2_ovf_pulse", 32'(ovf_a), 32'd1);
        check("t2_data_held", 32'(if_a.frame_data), 32'h0123);
        check("t2_valid_held", 32'(if_a.frame_valid), 32'd1);
        wait_cyc(1);
        check("t2_ovf_after", 32'(ovf_a), 32'd0);
        check("t2_data_held2", 32'(if_a.frame_data), 32'h0123);
        if_a.frame_ready = 1'b1;
        wait_cyc(1);
        check("t2_valid_fall", 32'(if_a.frame_valid), 32'd0);

        // Invalid pattern on digit 2; multi-hot enable ignored
        q_a.push_back('{data: 16'hA0FE, err: 4'b0100});
        show_a(7'h4F, 4'b0001, 5);
        show_a(7'h7E, 4'b0011, 10);
        show_a(7'h47, 4'b0010, 5);
        show_a(7'h01, 4'b0100, 5);
        show_a(7'h77, 4'b1000, 5);

        // Short pattern on digit 1 after a long one must not capture
        q_a.push_back('{data: 16'h89B5, err: 4'h0});
        show_a(7'h5B, 4'b0001, 5);
        show_a(7'h1F, 4'b0010, 20);
        show_a(7'h3D, 4'b0010, 2);
        show_a(7'h7B, 4'b0100, 5);
        show_a(7'h7F, 4'b1000, 5);

        // Reset in the middle of a frame discards the partial frame
        show_a(7'h4F, 4'b0001, 5);
        show_a(7'h4F, 4'b0010, 5);
        rst = 1'b1;
        wait_cyc(1);
        check("t5_rst_data", 32'(if_a.frame_data), 32'd0);
        check("t5_rst_err", 32'(if_a.frame_err), 32'd0);
        check("t5_rst_valid", 32'(if_a.frame_valid), 32'd0);
        check("t5_rst_ovf", 32'(ovf_a), 32'd0);
        rst = 1'b0;
        show_a(7'h6D, 4'b0100, 5);
        show_a(7'h79, 4'b1000, 5);
        wait_cyc(2);
        check("t5_no_partial_frame", 32'(if_a.frame_valid), 32'd0);
        q_a.push_back('{data: 16'h3201, err: 4'h0});
        show_a(7'h30, 4'b0001, 5);
        show_a(7'h7E, 4'b0010, 5);
        wait_cyc(3);

        // Active-low instance with ready tied high: back-to-back frames
        q_b.push_back('{data: 16'hFFFF, err: 4'h0});
        q_b.push_back('{data: 16'hFFFF, err: 4'h0});
        q_b.push_back('{data: 16'h3210, err: 4'h0});
        for (int f = 0; f < 2; f++) begin
            for (int d = 0; d < 4; d++) begin
                oh = 4'b0001 << d;
                show_b(7'h47, oh, 4);
            end
        end
        show_b(7'h7E, 4'b0001, 4);
        show_b(7'h30, 4'b0010, 4);
        show_b(7'h6D, 4'b0100, 4);
        show_b(7'h79, 4'b1000, 4);
        wait_cyc(6);

        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);
        check("a_overflow_count", 32'(ovf_seen_a), 32'd1);
        check("b_overflow_count", 32'(ovf_seen_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
